// File: rtl/tri_setup_if.sv
// Handshake bundle between fifo_reg, the triangle setup stage and the rasterizer.
// The master side drives the fifo/ack inputs; the slave side is tri_setup itself.
interface tri_setup_if;
    logic         fifo_ready;
    logic         dequeue;
    logic [95:0]  vertex_in;
    logic [95:0]  vertex_in2;
    logic [95:0]  vertex_in3;
    logic [95:0]  color_in;
    logic [95:0]  color_in2;
    logic [95:0]  color_in3;
    logic         tri_valid;
    logic         tri_ack;
    logic [50:0]  edge_a;
    logic [50:0]  edge_b;
    logic [98:0]  edge_c;
    logic [34:0]  area;
    logic [15:0]  bbox_xmin;
    logic [15:0]  bbox_xmax;
    logic [15:0]  bbox_ymin;
    logic [15:0]  bbox_ymax;
    logic [287:0] tri_color;
    logic         busy;
    logic         overflow;
    logic [15:0]  cull_count;

    modport master (
        output fifo_ready, vertex_in, vertex_in2, vertex_in3,
               color_in, color_in2, color_in3, tri_ack,
        input  dequeue, tri_valid, edge_a, edge_b, edge_c, area,
               bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, tri_color,
               busy, overflow, cull_count
    );

    modport slave (
        input  fifo_ready, vertex_in, vertex_in2, vertex_in3,
               color_in, color_in2, color_in3, tri_ack,
        output dequeue, tri_valid, edge_a, edge_b, edge_c, area,
               bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, tri_color,
               busy, overflow, cull_count
    );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: captures a triangle from fifo_reg, computes edge equations, area and
// clamped bounding box over six cycles, culls, and hands survivors to the rasterizer.
//
// state | meaning
// IDLE  | waiting for a buffered triangle
// E0-E2 | evaluate edge 0/1/2 on the shared multiplier pair
// FIN   | area, bounding box, cull decision, CCW normalisation
// OUT   | result presented, waiting for tri_ack
module tri_setup #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter bit CULL_BACK = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    tri_setup_if.slave   io_tri
);
    typedef enum logic [2:0] {S_IDLE, S_E0, S_E1, S_E2, S_FIN, S_OUT} state_t;

    localparam logic signed [15:0] LP_XMAX = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] LP_YMAX = 16'(SCREEN_H - 1);

    state_t              r_state;
    logic                r_dequeue, r_buf_full, r_overflow, r_valid;
    logic signed [15:0]  r_bx [3];
    logic signed [15:0]  r_by [3];
    logic [95:0]         r_bc [3];
    logic signed [15:0]  r_x [3];
    logic signed [15:0]  r_y [3];
    logic [95:0]         r_col [3];
    logic signed [16:0]  r_a [3];
    logic signed [16:0]  r_b [3];
    logic signed [32:0]  r_c [3];
    logic [50:0]         r_edge_a, r_edge_b;
    logic [98:0]         r_edge_c;
    logic [34:0]         r_area;
    logic [15:0]         r_xmin, r_xmax, r_ymin, r_ymax, r_cull_count;
    logic [287:0]        r_color;

    logic                w_cap, w_drain, w_neg, w_cull, w_unused;
    logic [1:0]          w_idx;
    logic signed [15:0]  w_xj, w_yj, w_xk, w_yk;
    logic signed [31:0]  w_pa, w_pb;
    logic signed [34:0]  w_area;
    logic signed [15:0]  w_xlo, w_xhi, w_ylo, w_yhi, w_xmin, w_xmax, w_ymin, w_ymax;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // dequeue masks ready so a slowly-deasserting fifo_reg is not captured twice
    assign w_cap   = io_tri.fifo_ready & ~r_dequeue;
    assign w_drain = (r_state == S_IDLE) & r_buf_full;

    // Edge i uses vertices j=i+1 and k=i+2 (mod 3)
    always_comb begin
        w_idx = 2'd0;
        w_xj  = r_x[1]; w_yj = r_y[1]; w_xk = r_x[2]; w_yk = r_y[2];
        case (r_state)
            S_E1: begin
                w_idx = 2'd1;
                w_xj  = r_x[2]; w_yj = r_y[2]; w_xk = r_x[0]; w_yk = r_y[0];
            end
            S_E2: begin
                w_idx = 2'd2;
                w_xj  = r_x[0]; w_yj = r_y[0]; w_xk = r_x[1]; w_yk = r_y[1];
            end
            default: ;
        endcase
    end

    assign w_pa   = w_xj * w_yk;
    assign w_pb   = w_xk * w_yj;
    assign w_area = 35'(r_c[0]) + 35'(r_c[1]) + 35'(r_c[2]);
    assign w_xlo  = min3(r_x[0], r_x[1], r_x[2]);
    assign w_xhi  = max3(r_x[0], r_x[1], r_x[2]);
    assign w_ylo  = min3(r_y[0], r_y[1], r_y[2]);
    assign w_yhi  = max3(r_y[0], r_y[1], r_y[2]);
    assign w_xmin = w_xlo[15] ? 16'sd0 : w_xlo;
    assign w_ymin = w_ylo[15] ? 16'sd0 : w_ylo;
    assign w_xmax = (w_xhi > LP_XMAX) ? LP_XMAX : w_xhi;
    assign w_ymax = (w_yhi > LP_YMAX) ? LP_YMAX : w_yhi;
    assign w_neg  = w_area[34];
    assign w_cull = (w_area == 35'sd0) | (w_xmin > w_xmax) | (w_ymin > w_ymax)
                  | (CULL_BACK & w_neg);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_dequeue    <= 1'b0;
            r_buf_full   <= 1'b0;
            r_overflow   <= 1'b0;
            r_valid      <= 1'b0;
            r_edge_a     <= '0;
            r_edge_b     <= '0;
            r_edge_c     <= '0;
            r_area       <= '0;
            r_xmin       <= '0;
            r_xmax       <= '0;
            r_ymin       <= '0;
            r_ymax       <= '0;
            r_color      <= '0;
            r_cull_count <= '0;
            for (int i = 0; i < 3; i++) begin
                r_bx[i] <= '0; r_by[i] <= '0; r_bc[i] <= '0;
                r_x[i]  <= '0; r_y[i]  <= '0; r_col[i] <= '0;
                r_a[i]  <= '0; r_b[i]  <= '0; r_c[i]   <= '0;
            end
        end else begin
            r_dequeue <= w_cap;
            if (w_cap) begin
                if (!r_buf_full || w_drain) begin
                    r_bx[0] <= io_tri.vertex_in[79:64];  r_by[0] <= io_tri.vertex_in[47:32];
                    r_bx[1] <= io_tri.vertex_in2[79:64]; r_by[1] <= io_tri.vertex_in2[47:32];
                    r_bx[2] <= io_tri.vertex_in3[79:64]; r_by[2] <= io_tri.vertex_in3[47:32];
                    r_bc[0] <= io_tri.color_in;
                    r_bc[1] <= io_tri.color_in2;
                    r_bc[2] <= io_tri.color_in3;
                    r_buf_full <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_drain) begin
                r_buf_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: if (r_buf_full) begin
                    r_x     <= r_bx;
                    r_y     <= r_by;
                    r_col   <= r_bc;
                    r_state <= S_E0;
                end
                S_E0, S_E1, S_E2: begin
                    r_a[w_idx] <= 17'(w_yj) - 17'(w_yk);
                    r_b[w_idx] <= 17'(w_xk) - 17'(w_xj);
                    r_c[w_idx] <= 33'(w_pa) - 33'(w_pb);
                    r_state    <= (r_state == S_E0) ? S_E1 :
                                  (r_state == S_E1) ? S_E2 : S_FIN;
                end
                S_FIN: begin
                    if (w_cull) begin
                        if (r_cull_count != 16'hFFFF) r_cull_count <= r_cull_count + 16'd1;
                        r_state <= S_IDLE;
                    end else begin
                        // Negating every edge flips winding to CCW; c1/c2 follow v1/v2
                        for (int i = 0; i < 3; i++) begin
                            r_edge_a[17*i +: 17] <= w_neg ? -r_a[i] : r_a[i];
                            r_edge_b[17*i +: 17] <= w_neg ? -r_b[i] : r_b[i];
                            r_edge_c[33*i +: 33] <= w_neg ? -r_c[i] : r_c[i];
                        end
                        r_area  <= w_neg ? -w_area : w_area;
                        r_color <= w_neg ? {r_col[1], r_col[2], r_col[0]}
                                         : {r_col[2], r_col[1], r_col[0]};
                        r_xmin  <= w_xmin;
                        r_xmax  <= w_xmax;
                        r_ymin  <= w_ymin;
                        r_ymax  <= w_ymax;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: if (io_tri.tri_ack) begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_unused = ^{io_tri.vertex_in[95:80],  io_tri.vertex_in[63:48],  io_tri.vertex_in[31:0],
                        io_tri.vertex_in2[95:80], io_tri.vertex_in2[63:48], io_tri.vertex_in2[31:0],
                        io_tri.vertex_in3[95:80], io_tri.vertex_in3[63:48], io_tri.vertex_in3[31:0]};

    assign io_tri.dequeue    = r_dequeue;
    assign io_tri.tri_valid  = r_valid;
    assign io_tri.edge_a     = r_edge_a;
    assign io_tri.edge_b     = r_edge_b;
    assign io_tri.edge_c     = r_edge_c;
    assign io_tri.area       = r_area;
    assign io_tri.bbox_xmin  = r_xmin;
    assign io_tri.bbox_xmax  = r_xmax;
    assign io_tri.bbox_ymin  = r_ymin;
    assign io_tri.bbox_ymax  = r_ymax;
    assign io_tri.tri_color  = r_color;
    assign io_tri.busy       = r_buf_full | (r_state != S_IDLE);
    assign io_tri.overflow   = r_overflow;
    assign io_tri.cull_count = r_cull_count;
endmodule

// File: tb/tb_tri_setup.sv
// Directed bench for tri_setup: one instance normalises back faces, a second one
// driven identically culls them.
module tb_tri_setup;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tri_setup_if if0 ();
    tri_setup_if if1 ();

    assign if1.fifo_ready = if0.fifo_ready;
    assign if1.vertex_in  = if0.vertex_in;
    assign if1.vertex_in2 = if0.vertex_in2;
    assign if1.vertex_in3 = if0.vertex_in3;
    assign if1.color_in   = if0.color_in;
    assign if1.color_in2  = if0.color_in2;
    assign if1.color_in3  = if0.color_in3;
    assign if1.tri_ack    = if0.tri_ack;

    tri_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst), .io_tri(if0.slave));
    tri_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACK(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst), .io_tri(if1.slave));

    typedef struct {
        logic signed [15:0] x0, y0, x1, y1, x2, y2;
        bit                 cull0, cull1, swap;
        logic signed [16:0] a0, a1, a2, b0, b1, b2;
        logic signed [32:0] c0, c1, c2;
        logic signed [34:0] area;
        logic [15:0]        xmin, xmax, ymin, ymax;
    } vec_t;

    vec_t vt [6];
    int n_pass = 0, n_total = 0;
    int deq_cnt = 0, exp_deq = 0, exp_cc0 = 0, exp_cc1 = 0;

    always @(negedge clk) if (if0.dequeue) deq_cnt++;

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] col(input int k, input int idx);
        return {32'(k), 32'hA5A5_5A5A, 32'(idx)};
    endfunction

    task automatic set_tri(input int i);
        if0.vertex_in  = {16'hDEAD, vt[i].x0, 16'hBEEF, vt[i].y0, 32'h1234_5678};
        if0.vertex_in2 = {16'hDEAD, vt[i].x1, 16'hBEEF, vt[i].y1, 32'h1234_5678};
        if0.vertex_in3 = {16'hDEAD, vt[i].x2, 16'hBEEF, vt[i].y2, 32'h1234_5678};
        if0.color_in   = col(0, i);
        if0.color_in2  = col(1, i);
        if0.color_in3  = col(2, i);
    endtask

    task automatic chk_result(input int i);
        logic [287:0] ec;
        ec = vt[i].swap ? {col(1, i), col(2, i), col(0, i)} : {col(2, i), col(1, i), col(0, i)};
        chk("tri_valid", {287'd0, if0.tri_valid}, 288'd1);
        chk("edge_a", if0.edge_a, {vt[i].a2, vt[i].a1, vt[i].a0});
        chk("edge_b", if0.edge_b, {vt[i].b2, vt[i].b1, vt[i].b0});
        chk("edge_c", if0.edge_c, {vt[i].c2, vt[i].c1, vt[i].c0});
        chk("area", if0.area, {vt[i].area});
        chk("bbox", {if0.bbox_xmin, if0.bbox_xmax, if0.bbox_ymin, if0.bbox_ymax},
            {vt[i].xmin, vt[i].xmax, vt[i].ymin, vt[i].ymax});
        chk("tri_color", if0.tri_color, ec);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!if0.tri_valid && lat < 12) begin
            step();
            lat++;
        end
    endtask

    task automatic ack_once();
        if0.tri_ack = 1'b1;
        step();
        if0.tri_ack = 1'b0;
        chk("valid_after_ack", {287'd0, if0.tri_valid}, 288'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        //        x0   y0   x1   y1   x2   y2  c0 c1 sw   a0   a1   a2   b0   b1   b2     c0      c1      c2  area  xmin xmax ymin ymax
        vt[0] = '{0,   0,   10,  0,   0,   10, 0, 0, 0, -10,  10,   0, -10,   0,  10,   100,      0,      0,  100,   0,  10,   0,  10};
        vt[1] = '{0,   0,   0,   10,  10,  0,  0, 1, 1, -10,   0,  10, -10,  10,   0,   100,      0,      0,  100,   0,  10,   0,  10};
        vt[2] = '{0,   0,   5,   5,   10,  10, 1, 1, 0,   0,   0,   0,   0,   0,   0,     0,      0,      0,    0,   0,   0,   0,   0};
        vt[3] = '{700, 10,  710, 10,  700, 20, 1, 1, 0,   0,   0,   0,   0,   0,   0,     0,      0,      0,    0,   0,   0,   0,   0};
        vt[4] = '{-5,  -3,  20,  4,   3,   30, 0, 0, 0, -26,  33,  -7, -17,  -8,  25,   588,    141,     40,  769,   0,  20,   0,  30};
        vt[5] = '{600, 400, 620, 490, 650, 410,0, 1, 1, -80, -10,  90, -30,  50, -20, 64300, -14000, -46000, 4300, 600, 639, 400, 479};

        rst = 1'b1;
        if0.fifo_ready = 1'b0;
        if0.tri_ack = 1'b0;
        set_tri(0);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_valid", {287'd0, if0.tri_valid}, 288'd0);
        chk("rst_dequeue", {287'd0, if0.dequeue}, 288'd0);
        chk("rst_busy", {287'd0, if0.busy}, 288'd0);
        chk("rst_overflow", {287'd0, if0.overflow}, 288'd0);
        chk("rst_cull_count", {272'd0, if0.cull_count}, 288'd0);
        chk("rst_results", {if0.edge_a, if0.edge_b, if0.edge_c, if0.area, if0.tri_color[50:0]}, 288'd0);

        // Single-cycle pulses through the vector table
        for (int i = 0; i < 6; i++) begin
            set_tri(i);
            if0.fifo_ready = 1'b1;
            step();
            if0.fifo_ready = 1'b0;
            exp_deq++;
            wait_valid(lat);
            if (!vt[i].cull0) begin
                chk("latency", 288'(lat), 288'd5);
                chk_result(i);
                chk("dut1_valid", {287'd0, if1.tri_valid}, {287'd0, !vt[i].cull1});
                ack_once();
            end else begin
                chk("culled_valid", {286'd0, if0.tri_valid, if1.tri_valid}, 288'd0);
            end
            repeat (2) step();
            if (vt[i].cull0) exp_cc0++;
            if (vt[i].cull1) exp_cc1++;
            chk("cull_count0", {272'd0, if0.cull_count}, 288'(exp_cc0));
            chk("cull_count1", {272'd0, if1.cull_count}, 288'(exp_cc1));
            chk("dequeue_count", 288'(deq_cnt), 288'(exp_deq));
            chk("idle_busy", {287'd0, if0.busy}, 288'd0);
        end

        // Ready held across the dequeue cycle: one capture only
        set_tri(0);
        if0.fifo_ready = 1'b1;
        step();
        step();
        if0.fifo_ready = 1'b0;
        exp_deq++;
        wait_valid(lat);
        chk_result(0);
        ack_once();
        repeat (10) step();
        chk("held_ready_no_second", {287'd0, if0.tri_valid}, 288'd0);
        chk("held_ready_dequeues", 288'(deq_cnt), 288'(exp_deq));

        // Three back-to-back triangles while the first waits for ack
        set_tri(4);
        if0.fifo_ready = 1'b1;
        step();
        if0.fifo_ready = 1'b0;
        step();
        set_tri(0);
        if0.fifo_ready = 1'b1;
        step();
        if0.fifo_ready = 1'b0;
        step();
        set_tri(5);
        if0.fifo_ready = 1'b1;
        step();
        if0.fifo_ready = 1'b0;
        chk("ovf_overflow", {286'd0, if0.overflow, if1.overflow}, 288'd3);
        step();
        exp_deq += 3;
        chk_result(4);
        chk("ovf_dequeues", 288'(deq_cnt), 288'(exp_deq));
        step();
        chk("ovf_valid_held", {286'd0, if0.tri_valid, if0.busy}, 288'd3);
        ack_once();
        wait_valid(lat);
        chk("ovf_second_latency", 288'(lat), 288'd5);
        chk_result(0);
        chk("ovf_sticky", {287'd0, if0.overflow}, 288'd1);
        ack_once();
        repeat (10) step();
        chk("ovf_third_dropped", {286'd0, if0.tri_valid, if1.tri_valid}, 288'd0);
        chk("ovf_cull_unchanged", {272'd0, if0.cull_count}, 288'(exp_cc0));

        // Reset while E1 is active and a second triangle is buffered
        set_tri(0);
        if0.fifo_ready = 1'b1;
        step();
        if0.fifo_ready = 1'b0;
        step();
        set_tri(4);
        if0.fifo_ready = 1'b1;
        step();
        if0.fifo_ready = 1'b0;
        exp_deq += 2;
        chk("pre_reset_busy", {287'd0, if0.busy}, 288'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_flags", {283'd0, if0.tri_valid, if0.dequeue, if0.busy, if0.overflow, if1.busy}, 288'd0);
        chk("mid_rst_cull_count", {256'd0, if0.cull_count, if1.cull_count}, 288'd0);
        chk("mid_rst_results", {if0.area, if0.edge_a, if0.edge_c, if0.bbox_xmax, if0.bbox_ymax}, 288'd0);
        repeat (10) step();
        chk("post_rst_no_valid", {286'd0, if0.tri_valid, if1.tri_valid}, 288'd0);
        chk("post_rst_dequeues", 288'(deq_cnt), 288'(exp_deq));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
